// File: rtl/fir_pkg.sv
// Shared widths, types and the output saturation helper for the FIR datapath.
// The module parameters default to these values. sat_out clamps a wide signed
// value into a w-bit signed range.
package fir_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned TAPS      = 16;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned OUT_SHIFT = 15;

  localparam int unsigned TAP_W = $clog2(TAPS);
  localparam int unsigned ACC_W = DATA_W + COEF_W + TAP_W;

  // Working width for saturation; must cover any ACC_W in use.
  localparam int unsigned SAT_W = 64;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  function automatic logic signed [SAT_W-1:0] sat_out(input logic signed [SAT_W-1:0] v,
                                                      input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate core of the FIR datapath.
// - clk_i/rst_ni : clock, async active-low reset
// - acc_clr_i    : clear accumulator (wins over acc_en_i)
// - acc_en_i     : acc += sample_i * coef_i (full-precision signed product)
// - store_i      : result_o <= sat(acc >>> OUT_SHIFT), truncating shift
// - result_o     : registered, saturated result
module fir_mac #(
  parameter int unsigned DATA_W    = fir_pkg::DATA_W,
  parameter int unsigned COEF_W    = fir_pkg::COEF_W,
  parameter int unsigned ACC_W     = fir_pkg::ACC_W,
  parameter int unsigned OUT_SHIFT = fir_pkg::OUT_SHIFT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     acc_clr_i,
  input  logic                     acc_en_i,
  input  logic                     store_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [DATA_W-1:0] result_o
);
  import fir_pkg::*;

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d, acc_q, acc_scaled;
  logic signed [SAT_W-1:0]  sat_val;
  logic signed [DATA_W-1:0] result_d, result_q;

  // Size casts keep signedness, so both operands are sign-extended first.
  assign prod       = PROD_W'(sample_i) * PROD_W'(coef_i);
  assign acc_scaled = acc_q >>> OUT_SHIFT;
  assign sat_val    = sat_out(SAT_W'(acc_scaled), DATA_W);

  always_comb begin
    acc_d = acc_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_comb begin
    result_d = result_q;
    if (store_i) begin
      result_d = sat_val[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/fir_datapath.sv
// FIR filter datapath driven by the control FSM's strobes.
// - Config: liczba_wsp / liczba_probek latched (and clamped) on the zapisz strobes
// - Counters: tap counter (wsp_addr, Petla_full), sample counter (wej_addr, Licznik_full)
// - Delay line fed from wej_data (1-cycle sync RAM), MAC + saturation in fir_mac
// - Output: wyj_addr/wyj_data registered on FSM_Acc_zapisz, wyj_we = FSM_wyj_wr
module fir_datapath #(
  parameter int unsigned DATA_W    = fir_pkg::DATA_W,
  parameter int unsigned COEF_W    = fir_pkg::COEF_W,
  parameter int unsigned TAPS      = fir_pkg::TAPS,
  parameter int unsigned ADDR_W    = fir_pkg::ADDR_W,
  parameter int unsigned OUT_SHIFT = fir_pkg::OUT_SHIFT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(TAPS):0]      liczba_wsp,
  input  logic [ADDR_W:0]            liczba_probek,
  input  logic                       FSM_zapisz_wsp,
  input  logic                       FSM_petla_en,
  input  logic                       FSM_reset_petla,
  input  logic                       FSM_zapisz_probki,
  input  logic                       FSM_reset_licznik,
  input  logic                       FSM_nowa_probka,
  input  logic                       FSM_nowa_shift,
  input  logic                       FSM_reset_shift,
  input  logic                       FSM_Acc_en,
  input  logic                       FSM_Acc_zapisz,
  input  logic                       FSM_reset_Acc,
  input  logic                       FSM_wyj_wr,
  output logic                       Petla_full,
  output logic                       Licznik_full,
  output logic [ADDR_W-1:0]          wej_addr,
  input  logic signed [DATA_W-1:0]   wej_data,
  output logic [$clog2(TAPS)-1:0]    wsp_addr,
  input  logic signed [COEF_W-1:0]   wsp_data,
  output logic [ADDR_W-1:0]          wyj_addr,
  output logic signed [DATA_W-1:0]   wyj_data,
  output logic                       wyj_we
);
  import fir_pkg::*;

  localparam int unsigned TAP_W = $clog2(TAPS);
  localparam int unsigned NT_W  = TAP_W + 1;
  localparam int unsigned ACC_W = DATA_W + COEF_W + TAP_W;

  logic [NT_W-1:0]          ntaps_d, ntaps_q;
  logic [ADDR_W:0]          nsamp_d, nsamp_q;
  logic [TAP_W-1:0]         tap_d, tap_q;
  logic [ADDR_W:0]          cnt_d, cnt_q;
  logic signed [DATA_W-1:0] dline_d [TAPS];
  logic signed [DATA_W-1:0] dline_q [TAPS];
  logic [ADDR_W-1:0]        wyj_addr_d, wyj_addr_q;

  // ntaps_q is never 0, so the subtraction cannot wrap.
  assign Petla_full   = (NT_W'(tap_q) == (ntaps_q - NT_W'(1)));
  assign Licznik_full = (cnt_q == nsamp_q);

  always_comb begin
    ntaps_d = ntaps_q;
    if (FSM_zapisz_wsp) begin
      if (liczba_wsp == '0) begin
        ntaps_d = NT_W'(1);
      end else if (liczba_wsp > NT_W'(TAPS)) begin
        ntaps_d = NT_W'(TAPS);
      end else begin
        ntaps_d = liczba_wsp;
      end
    end
  end

  always_comb begin
    nsamp_d = nsamp_q;
    if (FSM_zapisz_probki) begin
      nsamp_d = (liczba_probek == '0) ? (ADDR_W + 1)'(1) : liczba_probek;
    end
  end

  always_comb begin
    tap_d = tap_q;
    if (FSM_reset_petla) begin
      tap_d = '0;
    end else if (FSM_petla_en && !Petla_full) begin
      tap_d = tap_q + TAP_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (FSM_reset_licznik) begin
      cnt_d = '0;
    end else if (FSM_nowa_probka) begin
      cnt_d = cnt_q + (ADDR_W + 1)'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      dline_d[i] = dline_q[i];
    end
    if (FSM_reset_shift) begin
      for (int i = 0; i < TAPS; i++) begin
        dline_d[i] = '0;
      end
    end else if (FSM_nowa_shift) begin
      dline_d[0] = wej_data;
      for (int i = 1; i < TAPS; i++) begin
        dline_d[i] = dline_q[i-1];
      end
    end
  end

  // Captures the pre-increment counter when C also raises nowa_probka.
  always_comb begin
    wyj_addr_d = wyj_addr_q;
    if (FSM_Acc_zapisz) begin
      wyj_addr_d = cnt_q[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ntaps_q    <= NT_W'(1);
      nsamp_q    <= (ADDR_W + 1)'(1);
      tap_q      <= '0;
      cnt_q      <= '0;
      wyj_addr_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
      end
    end else begin
      ntaps_q    <= ntaps_d;
      nsamp_q    <= nsamp_d;
      tap_q      <= tap_d;
      cnt_q      <= cnt_d;
      wyj_addr_q <= wyj_addr_d;
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= dline_d[i];
      end
    end
  end

  fir_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .ACC_W     (ACC_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .acc_clr_i (FSM_reset_Acc),
    .acc_en_i  (FSM_Acc_en),
    .store_i   (FSM_Acc_zapisz),
    .sample_i  (dline_q[tap_q]),
    .coef_i    (wsp_data),
    .result_o  (wyj_data)
  );

  assign wej_addr = cnt_q[ADDR_W-1:0];
  assign wsp_addr = tap_q;
  assign wyj_addr = wyj_addr_q;
  assign wyj_we   = FSM_wyj_wr;

endmodule

// File: tb/tb_fir_datapath.sv
// Bench for fir_datapath: two instances (OUT_SHIFT 15 and 0) share the strobes,
// memories and config; a bench-side sequencer plays the control FSM and every
// written output is compared with a direct convolution model.
module tb_fir_datapath;
  import fir_pkg::*;

  localparam int NTAPS = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]  liczba_wsp;
  logic [10:0] liczba_probek;
  logic zapisz_wsp, petla_en, reset_petla, zapisz_probki, reset_licznik, nowa_probka;
  logic nowa_shift, reset_shift, acc_en, acc_zapisz, reset_acc, wyj_wr;

  logic        petla_full_a, licznik_full_a, wyj_we_a;
  logic        petla_full_b, licznik_full_b, wyj_we_b;
  logic [9:0]  wej_addr_a, wej_addr_b, wyj_addr_a, wyj_addr_b;
  logic [3:0]  wsp_addr_a, wsp_addr_b;
  sample_t     wej_data_a, wej_data_b, wyj_data_a, wyj_data_b;
  coef_t       wsp_data_a, wsp_data_b;

  sample_t xmem [1024];
  coef_t   hmem [NTAPS];
  longint  y_a [64];
  longint  y_b [64];

  int n_checks = 0;
  int n_fail   = 0;

  // Synchronous input RAM per instance, combinational coefficient ROM.
  always_ff @(posedge clk) begin
    wej_data_a <= xmem[wej_addr_a];
    wej_data_b <= xmem[wej_addr_b];
  end
  assign wsp_data_a = hmem[wsp_addr_a];
  assign wsp_data_b = hmem[wsp_addr_b];

  fir_datapath #(.OUT_SHIFT(15)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .liczba_wsp(liczba_wsp), .liczba_probek(liczba_probek),
    .FSM_zapisz_wsp(zapisz_wsp), .FSM_petla_en(petla_en), .FSM_reset_petla(reset_petla),
    .FSM_zapisz_probki(zapisz_probki), .FSM_reset_licznik(reset_licznik),
    .FSM_nowa_probka(nowa_probka), .FSM_nowa_shift(nowa_shift),
    .FSM_reset_shift(reset_shift), .FSM_Acc_en(acc_en), .FSM_Acc_zapisz(acc_zapisz),
    .FSM_reset_Acc(reset_acc), .FSM_wyj_wr(wyj_wr), .Petla_full(petla_full_a),
    .Licznik_full(licznik_full_a), .wej_addr(wej_addr_a), .wej_data(wej_data_a),
    .wsp_addr(wsp_addr_a), .wsp_data(wsp_data_a), .wyj_addr(wyj_addr_a),
    .wyj_data(wyj_data_a), .wyj_we(wyj_we_a)
  );

  fir_datapath #(.OUT_SHIFT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .liczba_wsp(liczba_wsp), .liczba_probek(liczba_probek),
    .FSM_zapisz_wsp(zapisz_wsp), .FSM_petla_en(petla_en), .FSM_reset_petla(reset_petla),
    .FSM_zapisz_probki(zapisz_probki), .FSM_reset_licznik(reset_licznik),
    .FSM_nowa_probka(nowa_probka), .FSM_nowa_shift(nowa_shift),
    .FSM_reset_shift(reset_shift), .FSM_Acc_en(acc_en), .FSM_Acc_zapisz(acc_zapisz),
    .FSM_reset_Acc(reset_acc), .FSM_wyj_wr(wyj_wr), .Petla_full(petla_full_b),
    .Licznik_full(licznik_full_b), .wej_addr(wej_addr_b), .wej_data(wej_data_b),
    .wsp_addr(wsp_addr_b), .wsp_data(wsp_data_b), .wyj_addr(wyj_addr_b),
    .wyj_data(wyj_data_b), .wyj_we(wyj_we_b)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_strobes();
    {zapisz_wsp, petla_en, reset_petla, zapisz_probki, reset_licznik, nowa_probka} = '0;
    {nowa_shift, reset_shift, acc_en, acc_zapisz, reset_acc, wyj_wr} = '0;
  endtask

  // y[s] = sat((sum_k x[s-k]*h[k]) >>> sh), x before sample 0 taken as 0.
  function automatic longint model_y(input int s, input int teff, input int sh);
    longint acc = 0;
    for (int k = 0; k < teff; k++) begin
      if (s - k >= 0) acc += longint'(xmem[s-k]) * longint'(hmem[k]);
    end
    acc = acc >>> sh;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_petla_full"}, petla_full_a, 1);
    check({tag, "_licznik_full"}, licznik_full_a, 0);
    check({tag, "_petla_full_s0"}, petla_full_b, 1);
    check({tag, "_licznik_full_s0"}, licznik_full_b, 0);
    check({tag, "_wyj_data"}, wyj_data_a, 0);
    check({tag, "_wyj_data_s0"}, wyj_data_b, 0);
    check({tag, "_wyj_addr"}, wyj_addr_a, 0);
    check({tag, "_wsp_addr"}, wsp_addr_a, 0);
    check({tag, "_wej_addr"}, wej_addr_a, 0);
    check({tag, "_wyj_we"}, wyj_we_a, 0);
  endtask

  task automatic start_cfg(input int ntaps, input int nsamp);
    clr_strobes();
    reset_petla = 1; reset_licznik = 1; reset_shift = 1; reset_acc = 1;
    zapisz_wsp = 1; zapisz_probki = 1;
    liczba_wsp = 5'(ntaps); liczba_probek = 11'(nsamp);
    @(negedge clk);
    clr_strobes();                      // idle: RAM fetches address 0
    @(negedge clk);
  endtask

  // Plays START, then A / B* / C / D per sample. abort_b >= 0 drops rst_n in
  // that B cycle of the first sample and returns.
  task automatic run_filter(input int ntaps, input int nsamp, input int abort_b);
    int teff, neff, nb, nout;
    bit last, done;
    teff = (ntaps == 0) ? 1 : ((ntaps > NTAPS) ? NTAPS : ntaps);
    neff = (nsamp == 0) ? 1 : nsamp;
    start_cfg(ntaps, nsamp);
    nout = 0;
    done = 0;
    for (int s = 0; s < neff + 2 && !done; s++) begin
      clr_strobes(); nowa_shift = 1; reset_petla = 1;          // A
      @(negedge clk);
      nb = 0;
      last = 0;
      while (!last && nb < NTAPS + 2) begin                    // B
        clr_strobes(); petla_en = 1; acc_en = 1;
        #1;
        last = petla_full_a;
        if (nb == abort_b) begin
          rst_n = 0;
          clr_strobes();
          #1;
          check_reset_state("midrst");
          repeat (2) @(negedge clk);
          rst_n = 1;
          @(negedge clk);
          return;
        end
        nb++;
        @(negedge clk);
      end
      check("mac_count", nb, teff);
      clr_strobes(); acc_zapisz = 1; nowa_probka = 1;          // C
      @(negedge clk);
      clr_strobes(); wyj_wr = 1; reset_acc = 1;                // D
      #1;
      check("wyj_we", wyj_we_a, 1);
      check("y_q15", wyj_data_a, model_y(s, teff, 15));
      check("y_s0", wyj_data_b, model_y(s, teff, 0));
      check("wyj_addr", wyj_addr_a, s);
      check("wyj_addr_s0", wyj_addr_b, s);
      check("licznik_full", licznik_full_a, (s == neff - 1) ? 1 : 0);
      if (s < 64) begin
        y_a[s] = longint'(wyj_data_a);
        y_b[s] = longint'(wyj_data_b);
      end
      nout++;
      done = licznik_full_a;
      @(negedge clk);
    end
    clr_strobes();
    check("n_outputs", nout, neff);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NTAPS; i++) hmem[i] = 16'($urandom);
    for (int i = 0; i < 64; i++) xmem[i] = 16'($urandom);
  endtask

  initial begin
    int imp_exp [5];
    int avg_exp [3];
    int nt, ns;
    imp_exp = '{1, 2, 3, 4, 0};
    avg_exp = '{50, 150, -50};
    rst_n = 0;
    liczba_wsp = '0;
    liczba_probek = '0;
    clr_strobes();
    for (int i = 0; i < 1024; i++) xmem[i] = '0;
    for (int i = 0; i < NTAPS; i++) hmem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1;
    @(negedge clk);

    // Impulse response through the unshifted instance
    hmem[0] = 1; hmem[1] = 2; hmem[2] = 3; hmem[3] = 4;
    xmem[0] = 1;
    run_filter(4, 5, -1);
    for (int i = 0; i < 5; i++) check("impulse_y", y_b[i], imp_exp[i]);

    // Q15 two-tap average
    hmem[0] = 16'h4000; hmem[1] = 16'h4000;
    xmem[0] = 100; xmem[1] = 200; xmem[2] = -300;
    run_filter(2, 3, -1);
    for (int i = 0; i < 3; i++) check("avg_y", y_a[i], avg_exp[i]);

    // Saturation at both rails
    hmem[0] = 16'h7FFF; hmem[1] = 16'h7FFF;
    xmem[0] = 16'h7FFF; xmem[1] = 16'h7FFF;
    run_filter(2, 2, -1);
    check("sat_pos", y_b[1], 32767);
    xmem[0] = -16'sd32768; xmem[1] = -16'sd32768;
    run_filter(2, 2, -1);
    check("sat_neg", y_b[1], -32768);

    // Config clamping
    rand_mem();
    run_filter(0, 4, -1);
    run_filter(NTAPS + 5, 3, -1);
    run_filter(5, 0, -1);

    // Tap counter holds past Petla_full
    start_cfg(3, 1);
    clr_strobes(); reset_petla = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      clr_strobes(); petla_en = 1;
      @(negedge clk);
    end
    clr_strobes();
    #1;
    check("hold_wsp_addr", wsp_addr_a, 2);
    check("hold_petla_full", petla_full_a, 1);
    check("hold_wsp_addr_s0", wsp_addr_b, 2);

    // Randomized configurations
    for (int r = 0; r < 4; r++) begin
      rand_mem();
      nt = int'($urandom_range(1, NTAPS));
      ns = int'($urandom_range(1, 20));
      run_filter(nt, ns, -1);
    end

    // Reset in the middle of B, then a clean rerun of the same config
    rand_mem();
    run_filter(7, 3, 3);
    run_filter(7, 3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_datapath.md
# fir_datapath

Arithmetic datapath of the FIR filter, sitting directly downstream of the filter control FSM. It executes the FSM's per-state control strobes: sample-counter and tap-loop counter updates, delay-line shifts, and multiply-accumulate steps. It also scales and saturates each result and writes it to the output sample memory. It reports `Petla_full` and `Licznik_full` back to the FSM.

## Interface
Parameters:
- `DATA_W`, 16: signed sample width, for input samples and output results.
- `COEF_W`, 16: signed coefficient width.
- `TAPS`, 16: maximum number of taps, which is also the delay-line depth.
- `ADDR_W`, 10: sample memory address width.
- `OUT_SHIFT`, 15: arithmetic right shift applied to the accumulator before saturation (Q15 coefficients).

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `liczba_wsp`, in, $clog2(TAPS)+1: tap count. Latched on `FSM_zapisz_wsp`.
- `liczba_probek`, in, ADDR_W+1: sample count. Latched on `FSM_zapisz_probki`.
- FSM strobes, in, 1 each: `FSM_zapisz_wsp`, `FSM_petla_en`, `FSM_reset_petla`, `FSM_zapisz_probki`, `FSM_reset_licznik`, `FSM_nowa_probka`, `FSM_nowa_shift`, `FSM_reset_shift`, `FSM_Acc_en`, `FSM_Acc_zapisz`, `FSM_reset_Acc`, `FSM_wyj_wr`.
- `Petla_full`, out, 1: combinational. High when tap counter == latched tap count − 1.
- `Licznik_full`, out, 1: combinational. High when sample counter == latched sample count.
- `wej_addr`, out, ADDR_W: input sample memory address; equals the sample counter's low bits.
- `wej_data`, in, DATA_W: input sample memory data. Synchronous RAM, 1-cycle read latency.
- `wsp_addr`, out, $clog2(TAPS): coefficient address; equals the tap counter.
- `wsp_data`, in, COEF_W: coefficient data. Combinational read, valid in the same cycle.
- `wyj_addr`, out, ADDR_W: output memory address (registered).
- `wyj_data`, out, DATA_W: output result (registered).
- `wyj_we`, out, 1: output write enable; equals `FSM_wyj_wr`.

## Operation
- Config latch, on each `zapisz` strobe:
  - Tap count: 0 is stored as 1; values above TAPS are stored as TAPS.
  - Sample count: 0 is stored as 1.
- Tap counter:
  - `FSM_reset_petla` sets it to 0.
  - `FSM_petla_en` increments it, but holds it when `Petla_full` is high (no wrap).
  - Reset has priority over increment.
- Sample counter, ADDR_W+1 bits:
  - `FSM_reset_licznik` sets it to 0.
  - `FSM_nowa_probka` increments it.
  - Reset has priority over increment.
- Delay line, TAPS×DATA_W:
  - `FSM_nowa_shift`: `d[0]<=wej_data`, `d[i]<=d[i-1]`.
  - `FSM_reset_shift` clears all entries and has priority over shifting.
- Accumulator, ACC_W = DATA_W+COEF_W+$clog2(TAPS), signed:
  - `FSM_Acc_en`: `acc += d[tap] * wsp_data`, using a full-precision signed product.
  - `FSM_reset_Acc` clears it and has priority over accumulation.
- `FSM_Acc_zapisz`:
  - `wyj_data <= sat(acc >>> OUT_SHIFT)`, saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. The shift truncates (no rounding).
  - `wyj_addr <=` sample counter low bits, sampled before any same-cycle `nowa_probka` increment.
- Per-sample FSM sequence and datapath response:
  - START: reset everything, latch config. Address 0 is presented.
  - A: shift in `wej_data`, reset the tap counter.
  - B: runs for the latched tap-count cycles, one MAC per cycle. The final MAC happens in the cycle where `Petla_full` is high.
  - C: store the result and increment the sample counter.
  - D: write to output memory and clear the accumulator.
- Simultaneous strobes: reset-type strobes always win. Independent registers update in parallel.

## Timing
- Reset values:
  - All counters, delay line, accumulator, `wyj_data` and `wyj_addr` are 0.
  - The tap-count and sample-count registers reset to 1.
  - Therefore after reset `Petla_full`=1 and `Licznik_full`=0.
- `wej_addr` changes the cycle after an increment. `wej_data` is valid one cycle after that, which is the FSM's next A state.
- `Petla_full` and `Licznik_full` are combinational from registers: 0 cycles from counter state, 1 cycle from the strobe.
- Throughput: TAPS_eff + 3 cycles per output sample.
- `wyj_data` and `wyj_addr` are stable from the cycle after `FSM_Acc_zapisz` until the next `FSM_Acc_zapisz`.
- An `rst_n` assertion mid-run immediately clears all state and deasserts `wyj_we`, unless the FSM holds `FSM_wyj_wr` high.

## Structure
- Package `fir_pkg`:
  - Width parameters `DATA_W`, `COEF_W`, `TAPS`, `ADDR_W`, `OUT_SHIFT`.
  - Derived `ACC_W` and `TAP_W`.
  - Typedefs `sample_t`, `coef_t`, `acc_t`.
  - Saturation function `sat_out`.
- Sub-module `fir_mac`: signed multiplier, accumulator with clear/enable priority, and scale/saturate output register. The counters and delay line stay in `fir_datapath`.

## Test plan
- Impulse response: `OUT_SHIFT`=0, h=[1,2,3,4], x=[1,0,0,0,0], N=5 → writes y=[1,2,3,4,0] at addresses 0..4. `Licznik_full` rises in the D state of sample 4.
- Q15 averaging: h=[0x4000,0x4000], x=[100,200,−300] → y=[50,150,−50].
- Saturation: `OUT_SHIFT`=0, h=[0x7FFF,0x7FFF].
  - x=all 0x7FFF → y1=0x7FFF (saturated).
  - x=all −32768 → y1=0x8000.
- Clamping:
  - `liczba_wsp`=0 → exactly 1 MAC per sample.
  - `liczba_wsp`=TAPS+5 → TAPS MACs per sample.
  - `liczba_probek`=0 → exactly one output written.
- Counter hold: hold `FSM_petla_en` 3 cycles beyond `Petla_full` → `wsp_addr` stays at taps−1 and `Petla_full` stays 1.
- Reset mid-B: drop `rst_n` for 2 cycles → all outputs return to reset values (`Petla_full`=1, `Licznik_full`=0). A subsequent full run produces outputs identical to a fresh run.
